// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle for fifo_stream_reader: the FIFO read port plus the valid/ready output stream.
// master = the reader; slave = the FIFO/consumer side.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_rd_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_data,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_data,
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous FIFO: issues read strobes, absorbs the one-cycle read
// latency and presents words as a valid/ready stream through a 2-entry buffer.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  fifo_stream_reader_if.master bus,
  output logic [CNT_W-1:0]     word_count,
  output logic                 idle
);

  logic                  pending;
  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic                  pop;
  logic [1:0]            occupancy;
  logic                  rd_en;

  assign pop = (count != 2'd0) && bus.out_ready;

  // Credit check: words buffered plus the word in flight, after this cycle's pop, must leave room.
  assign occupancy = count + {1'b0, pending} - {1'b0, pop};
  assign rd_en     = !rst && enable && !bus.fifo_empty && (occupancy < 2'd2);

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = (count != 2'd0);
  assign bus.out_data   = head;
  assign idle           = !pending && (count == 2'd0);

  // NOTE: sequential state is updated with non-blocking assignments so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= 1'b0;
      count      <= 2'd0;
      word_count <= '0;
    end else begin
      pending <= rd_en;
      if (pending && !pop) begin
        count <= count + 2'd1;
      end else if (!pending && pop) begin
        count <= count - 2'd1;
      end
      if (pop) begin
        word_count <= word_count + CNT_W'(1);
      end
    end
  end

  // NOTE: the data registers are reset as well because out_data must read zero out of reset;
  // tail is cleared alongside head so the buffer never exposes stale contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (pop && count == 2'd2) begin
        head <= tail;
      end
      // The capture is steered to head when the buffer is (or is becoming) empty at the head.
      if (pending) begin
        if (count == 2'd0 || (count == 2'd1 && pop)) begin
          head <= bus.fifo_data;
        end else begin
          tail <= bus.fifo_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: a FIFO model with registered read data feeds the DUT,
// a scoreboard queue holds the words in FIFO order and a monitor compares each delivered word.
module tb_fifo_stream_reader;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [CW-1:0] word_count;
  logic          idle;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .bus        (bus),
    .word_count (word_count),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] fifo_mem[256];
  logic [7:0]    fifo_wr_ptr = 8'd0;
  logic [7:0]    fifo_rd_ptr = 8'd0;

  assign bus.fifo_empty = (fifo_wr_ptr == fifo_rd_ptr);

  // FIFO model: data_out is registered and valid the cycle after an accepted read.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_rd_ptr   <= 8'd0;
      bus.fifo_data <= '0;
    end else if (bus.fifo_rd_en) begin
      bus.fifo_data <= fifo_mem[fifo_rd_ptr];
      fifo_rd_ptr   <= fifo_rd_ptr + 8'd1;
    end
  end

  // Monitor: scoreboard pops on every handshake, plus protocol invariants each cycle.
  int            inflight   = 0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] stall_data;
  logic [DW-1:0] exp_w;
  logic          mon_pop;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      inflight   = 0;
      stall_prev = 1'b0;
    end else begin
      mon_pop = bus.out_valid && bus.out_ready;
      if (mon_pop) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard_extra: got word %h, want no word", bus.out_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (bus.out_data !== exp_w) begin
            n_bad++;
            $display("FAIL scoreboard_data: got %h, want %h", bus.out_data, exp_w);
          end
        end
      end
      n_cmp++;
      if (bus.fifo_rd_en && bus.fifo_empty) begin
        n_bad++;
        $display("FAIL rd_while_empty: got rd_en=1 with empty=1, want rd_en=0");
      end
      inflight = inflight + int'(bus.fifo_rd_en) - int'(mon_pop);
      n_cmp++;
      if (inflight > 2) begin
        n_bad++;
        $display("FAIL outstanding: got %0d words outstanding, want <= 2", inflight);
      end
      if (stall_prev) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== stall_data) begin
          n_bad++;
          $display("FAIL stall_stable: got valid=%b data=%h, want valid=1 data=%h",
                   bus.out_valid, bus.out_data, stall_data);
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
    end
  end

  task automatic load(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[fifo_wr_ptr] = first + DW'(i);
      exp_q.push_back(first + DW'(i));
      fifo_wr_ptr = fifo_wr_ptr + 8'd1;
    end
  endtask

  // Asserts reset mid-cycle and holds it across two negedges so the monitor sees it.
  task automatic do_reset;
    @(negedge clk);
    #3;
    rst         = 1'b1;
    fifo_wr_ptr = 8'd0;
    exp_q.delete();
    enable        = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL por_idle: got %b, want 1", idle); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL por_valid: got %b, want 0", bus.out_valid); end
    n_cmp++; if (word_count !== 4'd0) begin n_bad++; $display("FAIL por_count: got %0d, want 0", word_count); end
    load(8'h31, 4);
    enable        = 1'b1;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_valid: got %b, want 1", bus.out_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b, want 0", bus.out_valid); end
    n_cmp++; if (bus.fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL rst_rd_en: got %b, want 0", bus.fifo_rd_en); end
    n_cmp++; if (word_count !== 4'd0) begin n_bad++; $display("FAIL rst_count: got %0d, want 0", word_count); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL rst_idle: got %b, want 1", idle); end
    n_cmp++; if (bus.out_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h, want 00", bus.out_data); end
    fifo_wr_ptr = 8'd0;
    exp_q.delete();
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (idle !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_quiet: got idle=%b valid=%b, want idle=1 valid=0", idle, bus.out_valid);
    end
  endtask

  task automatic test_single;
    int rd_n = 0, rd_first = -1, v_n = 0, v_first = -1;
    do_reset();
    load(8'hA5, 1);
    enable        = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bus.fifo_rd_en) begin rd_n++; if (rd_first < 0) rd_first = c; end
      if (bus.out_valid) begin v_n++; if (v_first < 0) v_first = c; end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (rd_n !== 1) begin n_bad++; $display("FAIL single_rd_cycles: got %0d, want 1", rd_n); end
    n_cmp++; if (rd_first !== 0) begin n_bad++; $display("FAIL single_rd_first: got %0d, want 0", rd_first); end
    n_cmp++; if (v_n !== 1) begin n_bad++; $display("FAIL single_valid_cycles: got %0d, want 1", v_n); end
    n_cmp++; if (v_first !== 2) begin n_bad++; $display("FAIL single_latency: got %0d, want 2", v_first); end
    n_cmp++; if (word_count !== 4'd1) begin n_bad++; $display("FAIL single_count: got %0d, want 1", word_count); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL single_idle: got %b, want 1", idle); end
  endtask

  task automatic test_stream;
    logic valid_at[14];
    logic idle_at[14];
    int   v_n = 0, v_first = -1, v_last = -1;
    do_reset();
    load(8'h01, 8);
    enable        = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      #1;
      valid_at[c] = bus.out_valid;
      idle_at[c]  = idle;
      if (bus.out_valid) begin v_n++; if (v_first < 0) v_first = c; v_last = c; end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (v_n !== 8) begin n_bad++; $display("FAIL stream_words: got %0d, want 8", v_n); end
    n_cmp++; if (v_first !== 2) begin n_bad++; $display("FAIL stream_first: got %0d, want 2", v_first); end
    n_cmp++; if (v_last !== 9) begin n_bad++; $display("FAIL stream_no_bubbles: got last=%0d, want 9", v_last); end
    if (v_last >= 0 && v_last < 13) begin
      n_cmp++; if (idle_at[v_last+1] !== 1'b1 || valid_at[v_last+1] !== 1'b0) begin
        n_bad++; $display("FAIL stream_drain_idle: got idle=%b valid=%b, want idle=1 valid=0",
                          idle_at[v_last+1], valid_at[v_last+1]);
      end
    end
    n_cmp++; if (word_count !== 4'd8) begin n_bad++; $display("FAIL stream_count: got %0d, want 8", word_count); end
  endtask

  task automatic test_back_pressure;
    int pops = 0;
    int c = 1;
    do_reset();
    load(8'h40, 8);
    enable        = 1'b1;
    bus.out_ready = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    n_cmp++; if (bus.fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL stall_rd_en: got %b, want 0", bus.fifo_rd_en); end
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid: got %b, want 1", bus.out_valid); end
    bus.out_ready = 1'b1;
    #1;
    n_cmp++; if (bus.fifo_rd_en !== 1'b1) begin n_bad++; $display("FAIL resume_rd_en: got %b, want 1", bus.fifo_rd_en); end
    if (bus.out_valid) pops++;
    @(negedge clk);
    while (exp_q.size() != 0 && c < 100) begin
      bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
      #1;
      if (bus.out_valid && bus.out_ready) pops++;
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL bp_drained: got %0d left, want 0", exp_q.size()); end
    n_cmp++; if (pops !== 8) begin n_bad++; $display("FAIL bp_pops: got %0d, want 8", pops); end
    n_cmp++; if (word_count !== 4'd8) begin n_bad++; $display("FAIL bp_count: got %0d, want 8", word_count); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL bp_idle: got %b, want 1", idle); end
  endtask

  task automatic test_enable_gating;
    int rd_n = 0, pops = 0, c = 0;
    do_reset();
    load(8'h60, 6);
    enable        = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 2) enable = 1'b0;
      #1;
      if (bus.fifo_rd_en) rd_n++;
      if (bus.out_valid) pops++;
      @(negedge clk);
    end
    #1;
    n_cmp++; if (rd_n !== 2) begin n_bad++; $display("FAIL en_strobes: got %0d, want 2", rd_n); end
    n_cmp++; if (pops !== 2) begin n_bad++; $display("FAIL en_words: got %0d, want 2", pops); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL en_idle: got %b, want 1", idle); end
    enable = 1'b1;
    #1;
    n_cmp++; if (bus.fifo_rd_en !== 1'b1) begin n_bad++; $display("FAIL en_resume: got %b, want 1", bus.fifo_rd_en); end
    @(negedge clk);
    while (exp_q.size() != 0 && c < 40) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL en_drained: got %0d left, want 0", exp_q.size()); end
    n_cmp++; if (word_count !== 4'd6) begin n_bad++; $display("FAIL en_count: got %0d, want 6", word_count); end
  endtask

  task automatic test_counter_wrap;
    int c = 0;
    do_reset();
    load(8'h10, 17);
    enable        = 1'b1;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && c < 60) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL wrap_drained: got %0d left, want 0", exp_q.size()); end
    n_cmp++; if (word_count !== 4'd1) begin n_bad++; $display("FAIL wrap_count: got %0d, want 1", word_count); end
  endtask

  initial begin
    rst           = 1'b0;
    enable        = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_back_pressure();
    test_enable_gating();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
